// File: rtl/loadable_updown_counter_if.sv
// Control and status bundle for loadable_updown_counter.
// The master drives controls; the slave (the counter) returns count and flags.
interface loadable_updown_counter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             en;
  logic             up;
  logic             sat;
  logic [WIDTH-1:0] count;
  logic             at_max;
  logic             at_min;
  logic             tc;
  logic             ovf;
  logic             unf;

  modport master (
    output clr, load, data_in, en, up, sat,
    input  count, at_max, at_min, tc, ovf, unf
  );

  modport slave (
    input  clr, load, data_in, en, up, sat,
    output count, at_max, at_min, tc, ovf, unf
  );
endinterface

// File: rtl/loadable_updown_counter.sv
// Modulo-(MAX_VAL+1) loadable up/down counter with wrap or saturate mode,
// terminal-count pulse and sticky overflow/underflow flags.
module loadable_updown_counter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_VAL = 2**WIDTH - 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  loadable_updown_counter_if.slave    bus
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] One    = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             at_max, at_min;

  assign at_max = (count_q == MaxVal);
  assign at_min = (count_q == '0);

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (bus.clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else if (bus.load) begin
      count_d = (bus.data_in > MaxVal) ? MaxVal : bus.data_in;
    end else if (bus.en) begin
      if (bus.up) begin
        // Bound decided by compare against MaxVal, not by carry-out.
        if (at_max) begin
          ovf_d = 1'b1;
          if (!bus.sat) begin
            count_d = '0;
            tc_d    = 1'b1;
          end
        end else begin
          count_d = count_q + One;
        end
      end else begin
        if (at_min) begin
          unf_d = 1'b1;
          if (!bus.sat) begin
            count_d = MaxVal;
            tc_d    = 1'b1;
          end
        end else begin
          count_d = count_q - One;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.count  = count_q;
  assign bus.at_max = at_max;
  assign bus.at_min = at_min;
  assign bus.tc     = tc_q;
  assign bus.ovf    = ovf_q;
  assign bus.unf    = unf_q;

endmodule

// File: tb/tb_loadable_updown_counter.sv
// Directed bench: a WIDTH=4/MAX_VAL=9 counter plus a WIDTH=4/MAX_VAL=15 full-range one.
module tb_loadable_updown_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   tc_seen = 0;

  always #5 clk = ~clk;

  loadable_updown_counter_if #(.WIDTH(4)) bus_a ();
  loadable_updown_counter_if #(.WIDTH(4)) bus_b ();

  loadable_updown_counter #(.WIDTH(4), .MAX_VAL(9)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  loadable_updown_counter #(.WIDTH(4), .MAX_VAL(15)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic clr, input logic load, input logic [3:0] din,
                       input logic en, input logic up, input logic sat);
    bus_a.clr     = clr;
    bus_a.load    = load;
    bus_a.data_in = din;
    bus_a.en      = en;
    bus_a.up      = up;
    bus_a.sat     = sat;
  endtask

  task automatic chk_a(input string tag, input int cnt, input logic tc, input logic ovf,
                       input logic unf);
    check({tag, ".count"}, 32'(bus_a.count), 32'(cnt));
    check({tag, ".tc"},    32'(bus_a.tc),    32'(tc));
    check({tag, ".ovf"},   32'(bus_a.ovf),   32'(ovf));
    check({tag, ".unf"},   32'(bus_a.unf),   32'(unf));
  endtask

  initial begin
    set_a(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    bus_b.clr = 1'b0; bus_b.load = 1'b0; bus_b.data_in = 4'd0;
    bus_b.en = 1'b0; bus_b.up = 1'b0; bus_b.sat = 1'b0;

    #12;
    chk_a("rst", 0, 1'b0, 1'b0, 1'b0);
    check("rst.at_min", 32'(bus_a.at_min), 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      step();
      check("idle.count", 32'(bus_a.count), 32'd0);
      check("idle.at_min", 32'(bus_a.at_min), 32'd1);
    end

    // Up wrap from 7.
    set_a(1'b0, 1'b1, 4'd7, 1'b0, 1'b1, 1'b0);
    step(); chk_a("upw.load", 7, 1'b0, 1'b0, 1'b0);
    set_a(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    step(); chk_a("upw.8", 8, 1'b0, 1'b0, 1'b0);
    step(); chk_a("upw.9", 9, 1'b0, 1'b0, 1'b0);
    check("upw.at_max", 32'(bus_a.at_max), 32'd1);
    step(); chk_a("upw.0", 0, 1'b1, 1'b1, 1'b0);
    check("upw.at_max0", 32'(bus_a.at_max), 32'd0);
    step(); chk_a("upw.1", 1, 1'b0, 1'b1, 1'b0);

    // Down wrap from 1; load has priority over en this cycle.
    set_a(1'b0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
    step(); chk_a("dnw.load", 1, 1'b0, 1'b1, 1'b0);
    set_a(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    step(); chk_a("dnw.0", 0, 1'b0, 1'b1, 1'b0);
    step(); chk_a("dnw.9", 9, 1'b1, 1'b1, 1'b1);
    step(); chk_a("dnw.8", 8, 1'b0, 1'b1, 1'b1);

    set_a(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step(); chk_a("clr", 0, 1'b0, 1'b0, 1'b0);

    // Saturate high then low.
    set_a(1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
    step(); chk_a("sat.load8", 8, 1'b0, 1'b0, 1'b0);
    set_a(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
    step(); chk_a("sat.up1", 9, 1'b0, 1'b0, 1'b0);
    step(); chk_a("sat.up2", 9, 1'b0, 1'b1, 1'b0);
    step(); chk_a("sat.up3", 9, 1'b0, 1'b1, 1'b0);
    set_a(1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
    step(); chk_a("sat.load1", 1, 1'b0, 1'b1, 1'b0);
    set_a(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    step(); chk_a("sat.dn1", 0, 1'b0, 1'b1, 1'b0);
    step(); chk_a("sat.dn2", 0, 1'b0, 1'b1, 1'b1);
    step(); chk_a("sat.dn3", 0, 1'b0, 1'b1, 1'b1);

    // Load clamp keeps sticky flags; clr beats load.
    set_a(1'b0, 1'b1, 4'd14, 1'b1, 1'b1, 1'b0);
    step(); chk_a("clamp", 9, 1'b0, 1'b1, 1'b1);
    set_a(1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    step(); chk_a("clr_load", 0, 1'b0, 1'b0, 1'b0);

    // Async reset mid-count with flags set.
    set_a(1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
    step(); chk_a("mid.load9", 9, 1'b0, 1'b0, 1'b0);
    set_a(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    step(); chk_a("mid.wrap", 0, 1'b1, 1'b1, 1'b0);
    set_a(1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    step(); chk_a("mid.load5", 5, 1'b0, 1'b1, 1'b0);
    set_a(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_a("mid.rst", 0, 1'b0, 1'b0, 1'b0);
    step(); chk_a("mid.rst_hold", 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    step(); chk_a("mid.first", 1, 1'b0, 1'b0, 1'b0);
    set_a(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Full binary range: 0 -> 1..15,0,1 with one tc pulse.
    bus_b.en = 1'b1; bus_b.up = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      step();
      check("full.count", 32'(bus_b.count), 32'(i % 16));
      check("full.tc", 32'(bus_b.tc), (i == 16) ? 32'd1 : 32'd0);
      if (bus_b.tc) tc_seen++;
    end
    check("full.tc_pulses", 32'(tc_seen), 32'd1);
    check("full.ovf", 32'(bus_b.ovf), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
